pa_ifu_ibuf_pop_ctrl: RTL and testbench

//  Pop side of the IFU instruction buffer, directly downstream of the per-entry ibuf storage.

---
 rtl/pa_ifu_ibuf_pop_ctrl.sv | 109 ++++++++++
 tb/tb_pa_ifu_ibuf_pop_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pa_ifu_ibuf_pop_ctrl.sv
// IFU instruction-buffer pop control: assembles one RVC/RV32 instruction per cycle from the
// two oldest ibuf halfwords into a registered issue slot, retires consumed entries, owns pop_ptr.
module pa_ifu_ibuf_pop_ctrl #(
  parameter int ENTRY_NUM = 8,
  parameter int PTR_W     = 3,
  parameter int HINFO_W   = 15
) (
  input  logic                           forever_cpuclk,
  input  logic                           cpurst,
  input  logic                           ibuf_flush_en,
  input  logic [ENTRY_NUM-1:0]           ibuf_entry_vld_vec,
  input  logic [16*ENTRY_NUM-1:0]        ibuf_entry_inst_vec,
  input  logic [2*ENTRY_NUM-1:0]         ibuf_entry_pred_taken_vec,
  input  logic [HINFO_W*ENTRY_NUM-1:0]   ibuf_entry_halt_info_vec,
  input  logic [ENTRY_NUM-1:0]           ibuf_entry_acc_err_vec,
  input  logic                           id_ibuf_inst_rdy,
  output logic [ENTRY_NUM-1:0]           ibuf_entry_retire_vec,
  output logic                           ibuf_id_inst_vld,
  output logic [31:0]                    ibuf_id_inst,
  output logic                           ibuf_id_inst_16bit,
  output logic [1:0]                     ibuf_id_pred_taken,
  output logic [HINFO_W-1:0]             ibuf_id_halt_info,
  output logic                           ibuf_id_acc_err,
  output logic [PTR_W-1:0]               ibuf_pop_ptr
);

  typedef struct packed {
    logic [31:0]        inst;
    logic               is16;
    logic [1:0]         pred_taken;
    logic [HINFO_W-1:0] halt_info;
    logic               acc_err;
  } slot_t;

  logic [ENTRY_NUM-1:0][15:0]        ent_inst;
  logic [ENTRY_NUM-1:0][1:0]         ent_pt;
  logic [ENTRY_NUM-1:0][HINFO_W-1:0] ent_hinfo;

  for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_ent
    assign ent_inst[i]  = ibuf_entry_inst_vec[16*i +: 16];
    assign ent_pt[i]    = ibuf_entry_pred_taken_vec[2*i +: 2];
    assign ent_hinfo[i] = ibuf_entry_halt_info_vec[HINFO_W*i +: HINFO_W];
  end

  logic [PTR_W-1:0] pop_ptr;
  logic [PTR_W-1:0] h1_ptr;
  logic             h0_vld, h1_vld, h0_err, h1_err;
  logic [15:0]      h0_inst, h1_inst;
  logic             cand_16, cand_32, cand, load;
  slot_t            slot_q, slot_d;
  logic             vld_q;

  // Wrap comes for free from PTR_W truncation since ENTRY_NUM is a power of 2.
  assign h1_ptr  = pop_ptr + PTR_W'(1);
  assign h0_vld  = ibuf_entry_vld_vec[pop_ptr];
  assign h1_vld  = ibuf_entry_vld_vec[h1_ptr];
  assign h0_err  = ibuf_entry_acc_err_vec[pop_ptr];
  assign h1_err  = ibuf_entry_acc_err_vec[h1_ptr];
  assign h0_inst = ent_inst[pop_ptr];
  assign h1_inst = ent_inst[h1_ptr];

  // A faulted H0 issues alone: its length bits are not trustworthy.
  assign cand_16 = h0_vld & (h0_err | (h0_inst[1:0] != 2'b11));
  assign cand_32 = h0_vld & ~h0_err & (h0_inst[1:0] == 2'b11) & h1_vld;
  assign cand    = cand_16 | cand_32;
  assign load    = cand & (~vld_q | id_ibuf_inst_rdy) & ~ibuf_flush_en & ~cpurst;

  always_comb begin
    slot_d.inst       = cand_32 ? {h1_inst, h0_inst} : {16'h0000, h0_inst};
    slot_d.is16       = ~cand_32;
    slot_d.pred_taken = cand_32 ? ent_pt[h1_ptr] : ent_pt[pop_ptr];
    slot_d.halt_info  = ent_hinfo[pop_ptr];
    slot_d.acc_err    = h0_err | (cand_32 & h1_err);
  end

  always_comb begin
    ibuf_entry_retire_vec = '0;
    if (load) begin
      ibuf_entry_retire_vec[pop_ptr] = 1'b1;
      if (cand_32) ibuf_entry_retire_vec[h1_ptr] = 1'b1;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      pop_ptr <= '0;
      vld_q   <= 1'b0;
      slot_q  <= '0;
    end else if (ibuf_flush_en) begin
      pop_ptr <= '0;
      vld_q   <= 1'b0;
    end else if (load) begin
      pop_ptr <= pop_ptr + (cand_32 ? PTR_W'(2) : PTR_W'(1));
      vld_q   <= 1'b1;
      slot_q  <= slot_d;
    end else if (vld_q & id_ibuf_inst_rdy) begin
      vld_q   <= 1'b0;
    end
  end

  assign ibuf_id_inst_vld   = vld_q;
  assign ibuf_id_inst       = slot_q.inst;
  assign ibuf_id_inst_16bit = slot_q.is16;
  assign ibuf_id_pred_taken = slot_q.pred_taken;
  assign ibuf_id_halt_info  = slot_q.halt_info;
  assign ibuf_id_acc_err    = slot_q.acc_err;
  assign ibuf_pop_ptr       = pop_ptr;

endmodule

// File: tb/tb_pa_ifu_ibuf_pop_ctrl.sv
// Directed bench for pa_ifu_ibuf_pop_ctrl; the bench plays the ibuf storage, clearing
// entry valids itself after each retire and on flush.
module tb_pa_ifu_ibuf_pop_ctrl;
  localparam int N = 8;
  localparam int PW = 3;
  localparam int HW = 15;

  logic            clk = 1'b0;
  logic            cpurst, flush, rdy;
  logic [N-1:0]    vld_vec, err_vec, retire;
  logic [16*N-1:0] inst_vec;
  logic [2*N-1:0]  pt_vec;
  logic [HW*N-1:0] hi_vec;
  logic            o_vld, o_16, o_err;
  logic [31:0]     o_inst;
  logic [1:0]      o_pt;
  logic [HW-1:0]   o_hi;
  logic [PW-1:0]   o_ptr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pa_ifu_ibuf_pop_ctrl #(.ENTRY_NUM(N), .PTR_W(PW), .HINFO_W(HW)) dut (
    .forever_cpuclk            (clk),
    .cpurst                    (cpurst),
    .ibuf_flush_en             (flush),
    .ibuf_entry_vld_vec        (vld_vec),
    .ibuf_entry_inst_vec       (inst_vec),
    .ibuf_entry_pred_taken_vec (pt_vec),
    .ibuf_entry_halt_info_vec  (hi_vec),
    .ibuf_entry_acc_err_vec    (err_vec),
    .id_ibuf_inst_rdy          (rdy),
    .ibuf_entry_retire_vec     (retire),
    .ibuf_id_inst_vld          (o_vld),
    .ibuf_id_inst              (o_inst),
    .ibuf_id_inst_16bit        (o_16),
    .ibuf_id_pred_taken        (o_pt),
    .ibuf_id_halt_info         (o_hi),
    .ibuf_id_acc_err           (o_err),
    .ibuf_pop_ptr              (o_ptr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ent(input int i, input logic [15:0] inst, input logic [1:0] pt,
                         input logic [HW-1:0] hi, input logic err);
    vld_vec[i]           = 1'b1;
    inst_vec[16*i +: 16] = inst;
    pt_vec[2*i +: 2]     = pt;
    hi_vec[HW*i +: HW]   = hi;
    err_vec[i]           = err;
  endtask

  initial begin
    cpurst = 1'b1; flush = 1'b0; rdy = 1'b1;
    vld_vec = '0; err_vec = '0; inst_vec = '0; pt_vec = '0; hi_vec = '0;

    // T1 reset
    tick(); tick();
    chk("rst_vld", 64'(o_vld), 64'd0);
    chk("rst_ptr", 64'(o_ptr), 64'd0);
    chk("rst_retire", 64'(retire), 64'd0);
    chk("rst_inst", 64'(o_inst), 64'd0);
    cpurst = 1'b0;

    // T2 mixed stream
    set_ent(0, 16'h4501, 2'b00, '0, 1'b0);
    set_ent(1, 16'h0513, 2'b00, '0, 1'b0);
    set_ent(2, 16'h0000, 2'b00, '0, 1'b0);
    #1 chk("t2_retire0", 64'(retire), 64'h01);
    tick();
    chk("t2_inst0", 64'(o_inst), 64'h4501);
    chk("t2_16b0", 64'(o_16), 64'd1);
    chk("t2_vld0", 64'(o_vld), 64'd1);
    chk("t2_ptr0", 64'(o_ptr), 64'd1);
    vld_vec[0] = 1'b0;
    #1 chk("t2_retire1", 64'(retire), 64'h06);
    tick();
    chk("t2_inst1", 64'(o_inst), 64'h00000513);
    chk("t2_16b1", 64'(o_16), 64'd0);
    chk("t2_ptr1", 64'(o_ptr), 64'd3);
    vld_vec[2:1] = 2'b00;
    #1 chk("t2_retire_idle", 64'(retire), 64'd0);
    tick();
    chk("t2_drain_vld", 64'(o_vld), 64'd0);

    // Back-to-back 16-bit pops 3..6 to walk pop_ptr up to 7
    for (int k = 3; k <= 6; k++) set_ent(k, 16'h4001 | 16'(k << 4), 2'(k), '0, 1'b0);
    for (int k = 3; k <= 6; k++) begin
      #1 chk("b2b_retire", 64'(retire), 64'(1 << k));
      tick();
      chk("b2b_vld", 64'(o_vld), 64'd1);
      chk("b2b_inst", 64'(o_inst), 64'(16'h4001 | 16'(k << 4)));
      chk("b2b_pt", 64'(o_pt), 64'(k % 4));
      chk("b2b_ptr", 64'(o_ptr), 64'(k + 1));
      vld_vec[k] = 1'b0;
    end

    // T3 wrap: 32-bit across entries 7 and 0
    set_ent(7, 16'h0093, 2'b01, '0, 1'b0);
    set_ent(0, 16'h0010, 2'b10, '0, 1'b0);
    #1 chk("t3_retire", 64'(retire), 64'h81);
    tick();
    chk("t3_inst", 64'(o_inst), 64'h00100093);
    chk("t3_16b", 64'(o_16), 64'd0);
    chk("t3_pt", 64'(o_pt), 64'h2);
    chk("t3_ptr", 64'(o_ptr), 64'd1);
    vld_vec[7] = 1'b0; vld_vec[0] = 1'b0;

    // T4 backpressure
    rdy = 1'b0;
    set_ent(1, 16'h4501, 2'b00, '0, 1'b0);
    set_ent(2, 16'h8082, 2'b00, '0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1 chk("t4_hold_retire", 64'(retire), 64'd0);
      tick();
      chk("t4_hold_inst", 64'(o_inst), 64'h00100093);
      chk("t4_hold_vld", 64'(o_vld), 64'd1);
      chk("t4_hold_ptr", 64'(o_ptr), 64'd1);
    end
    rdy = 1'b1;
    #1 chk("t4_retire1", 64'(retire), 64'h02);
    tick();
    chk("t4_inst1", 64'(o_inst), 64'h4501);
    chk("t4_ptr1", 64'(o_ptr), 64'd2);
    vld_vec[1] = 1'b0;
    #1 chk("t4_retire2", 64'(retire), 64'h04);
    tick();
    chk("t4_inst2", 64'(o_inst), 64'h8082);
    chk("t4_ptr2", 64'(o_ptr), 64'd3);
    vld_vec[2] = 1'b0;
    tick();
    chk("t4_drain_vld", 64'(o_vld), 64'd0);

    // T5 access error: faulted 32-bit-looking H0 issues alone, then H1 error on 32-bit
    set_ent(3, 16'hA513, 2'b00, '0, 1'b1);
    set_ent(4, 16'h0513, 2'b00, 15'h1abc, 1'b0);
    set_ent(5, 16'h1234, 2'b11, '0, 1'b1);
    #1 chk("t5_retire0", 64'(retire), 64'h08);
    tick();
    chk("t5_inst0", 64'(o_inst), 64'h0000A513);
    chk("t5_16b0", 64'(o_16), 64'd1);
    chk("t5_err0", 64'(o_err), 64'd1);
    chk("t5_ptr0", 64'(o_ptr), 64'd4);
    vld_vec[3] = 1'b0;
    #1 chk("t5_retire1", 64'(retire), 64'h30);
    tick();
    chk("t5_inst1", 64'(o_inst), 64'h12340513);
    chk("t5_16b1", 64'(o_16), 64'd0);
    chk("t5_err1", 64'(o_err), 64'd1);
    chk("t5_hinfo1", 64'(o_hi), 64'h1abc);
    chk("t5_pt1", 64'(o_pt), 64'h3);
    chk("t5_ptr1", 64'(o_ptr), 64'd6);
    vld_vec[5:4] = 2'b00; err_vec = '0;
    tick();
    chk("t5_drain_vld", 64'(o_vld), 64'd0);

    // T6 split 32-bit waiting on H1, flushed when H1 shows up
    set_ent(6, 16'h0013, 2'b00, '0, 1'b0);
    #1 chk("t6_wait_retire", 64'(retire), 64'd0);
    tick();
    chk("t6_wait_vld", 64'(o_vld), 64'd0);
    chk("t6_wait_ptr", 64'(o_ptr), 64'd6);
    set_ent(7, 16'h0000, 2'b00, '0, 1'b0);
    flush = 1'b1;
    #1 chk("t6_flush_retire", 64'(retire), 64'd0);
    tick();
    chk("t6_flush_vld", 64'(o_vld), 64'd0);
    chk("t6_flush_ptr", 64'(o_ptr), 64'd0);
    chk("t6_flush_hold", 64'(o_inst), 64'h12340513);
    flush = 1'b0; vld_vec = '0;

    // Reset mid-operation, then a clean restart
    set_ent(0, 16'h4501, 2'b00, '0, 1'b0);
    tick();
    chk("mr_vld", 64'(o_vld), 64'd1);
    vld_vec[0] = 1'b0;
    set_ent(1, 16'h4502, 2'b00, '0, 1'b0);
    cpurst = 1'b1;
    #1 chk("mr_retire", 64'(retire), 64'd0);
    tick();
    chk("mr_vld_rst", 64'(o_vld), 64'd0);
    chk("mr_ptr_rst", 64'(o_ptr), 64'd0);
    chk("mr_inst_rst", 64'(o_inst), 64'd0);
    cpurst = 1'b0; vld_vec = '0;
    set_ent(0, 16'h0001, 2'b00, '0, 1'b0);
    tick();
    chk("mr_restart_vld", 64'(o_vld), 64'd1);
    chk("mr_restart_inst", 64'(o_inst), 64'h1);
    vld_vec[0] = 1'b0;

    // Flush dominates a stalled valid slot
    rdy = 1'b0; flush = 1'b1;
    tick();
    chk("fl_vld", 64'(o_vld), 64'd0);
    chk("fl_ptr", 64'(o_ptr), 64'd0);
    chk("fl_hold", 64'(o_inst), 64'h1);
    flush = 1'b0; rdy = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
